// File: rtl/rom_fetch.sv
// rom_fetch: instruction fetch front-end between decode and the boot ROM.
// Issues word addresses to a ROM with one cycle of read latency, captures
// returned words into a small prefetch FIFO, and presents {pc, instruction}
// to decode over a valid/ready handshake. A redirect flushes everything
// buffered or in flight and restarts fetch at the new PC.
module rom_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so that occupancy + reservation never overflows.
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);

    // Fetch sequencing state.
    logic [31:0]      fetch_pc_r;
    logic             inflight_r;
    logic [31:0]      inflight_pc_r;

    // Prefetch FIFO storage and bookkeeping; each entry is {pc, instruction}.
    logic [63:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Combinational control.
    logic             pop_s;
    logic             push_s;
    logic             room_s;
    logic             issue_s;
    logic [31:0]      redirect_base_s;
    logic [OCC_W-1:0] occupancy_s;
    logic [OCC_W-1:0] limit_s;
    logic             unused_s;

    // Handshake, issue decision and ROM address selection.
    always_comb begin
        inst_valid      = (count_r != {CNT_W{1'b0}});
        pop_s           = inst_valid & inst_ready;
        // Redirect target with the byte-offset bits dropped.
        redirect_base_s = {redirect_pc[31:2], 2'b00};
        // Slots already committed: buffered words plus the word still coming
        // back from the ROM. A pop this cycle frees one slot in advance.
        occupancy_s     = OCC_W'(count_r) + OCC_W'(inflight_r);
        limit_s         = DEPTH_V + OCC_W'(pop_s);
        room_s          = (occupancy_s < limit_s);
        issue_s         = fetch_en & room_s;
        // In-flight data is discarded when a redirect lands in the same cycle.
        push_s          = inflight_r & ~redirect_valid;
        rom_addr        = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00}
                                         : {fetch_pc_r[ADDR_W-1:2], 2'b00};
        unused_s        = ^redirect_pc[1:0];
    end

    // Head of the FIFO drives decode straight from storage registers.
    always_comb begin
        inst_data = mem_r[rd_ptr_r][31:0];
        inst_pc   = mem_r[rd_ptr_r][63:32];
    end

    // Fetch PC, in-flight tracking and FIFO pointers/count; redirect wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            if (fetch_en) begin
                inflight_r    <= 1'b1;
                inflight_pc_r <= redirect_base_s;
                fetch_pc_r    <= redirect_base_s + 32'd4;
            end else begin
                inflight_r <= 1'b0;
                fetch_pc_r <= redirect_base_s;
            end
        end else begin
            if (issue_s) begin
                inflight_r    <= 1'b1;
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + 32'd4;
            end else begin
                inflight_r <= 1'b0;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FIFO storage: captures the ROM word together with the PC it was fetched for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'h0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {inflight_pc_r, rom_data};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed and randomized checks for rom_fetch against an
// in-order PC stream reference and a behavioural ROM model.
module tb_rom_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] rom [256];

    always #5 clk = ~clk;

    rom_fetch #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (10),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    // Registered-read boot ROM model.
    always @(posedge clk) rom_data <= rom[rom_addr[9:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Score any handshake completing at the coming edge, then advance one cycle.
    task automatic cyc();
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            chk("sb_pc", {32'h0, inst_pc}, {32'h0, exp_pc});
            chk("sb_data", {32'h0, inst_data}, {32'h0, rom[exp_pc[9:2]]});
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        @(negedge clk);
    endtask

    task automatic redir(input logic [31:0] tgt, input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] base;
        base = {tgt[31:2], 2'b00};
        inst_ready = 1'b0;
        repeat (4) cyc();
        chk("full_before_redirect", {62'h0, dut.count_r}, 64'(DEPTH));
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cyc();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        chk("r1_valid", {63'h0, inst_valid}, 64'h0);
        inst_ready = 1'b1;
        cyc();
        chk("r2_valid", {63'h0, inst_valid}, 64'h1);
        chk("r2_pc", {32'h0, inst_pc}, {32'h0, base});
        chk("r2_data", {32'h0, inst_data}, {32'h0, d2});
        cyc();
        chk("r3_pc", {32'h0, inst_pc}, {32'h0, base + 32'd4});
        chk("r3_data", {32'h0, inst_data}, {32'h0, d3});
        repeat (3) cyc();
    endtask

    initial begin
        logic [31:0] head;
        int          d0;

        for (int i = 0; i < 256; i++) rom[i] = 32'((i + 1) << 7) | 32'h13;
        rom[91] = 32'hfe01_0113;

        // Reset values.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_data", {32'h0, inst_data}, 64'h0);
        chk("rst_pc", {32'h0, inst_pc}, 64'h0);
        chk("rst_rom_addr", {54'h0, rom_addr}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch at full throughput.
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        exp_pc     = 32'h0;
        cyc();
        chk("first_edge_valid", {63'h0, inst_valid}, 64'h0);
        cyc();
        chk("second_edge_valid", {63'h0, inst_valid}, 64'h1);
        chk("first_pc", {32'h0, inst_pc}, 64'h0);
        chk("first_data", {32'h0, inst_data}, 64'h93);
        for (int i = 0; i < 6; i++) begin
            chk("stream_valid", {63'h0, inst_valid}, 64'h1);
            cyc();
        end

        // Backpressure: FIFO fills, fetch stops two words ahead of the head.
        inst_ready = 1'b0;
        repeat (10) cyc();
        chk("bp_count", {62'h0, dut.count_r}, 64'(DEPTH));
        chk("bp_fetch_pc", {32'h0, dut.fetch_pc_r}, {32'h0, exp_pc + 32'(4 * DEPTH)});
        cyc();
        cyc();
        chk("bp_fetch_pc_hold", {32'h0, dut.fetch_pc_r}, {32'h0, exp_pc + 32'(4 * DEPTH)});
        chk("bp_inflight", {63'h0, dut.inflight_r}, 64'h0);
        inst_ready = 1'b1;
        repeat (8) cyc();

        // Redirects from a full FIFO: aligned, misaligned, and ROM wrap.
        redir(32'h0000_016C, 32'hfe01_0113, 32'h0000_2E93);
        redir(32'h0000_016E, 32'hfe01_0113, 32'h0000_2E93);
        redir(32'h0000_03FC, 32'h0000_8013, 32'h0000_0093);

        // fetch_en drop with one fetch in flight: head and in-flight word delivered.
        chk("toggle_inflight", {63'h0, dut.inflight_r}, 64'h1);
        fetch_en = 1'b0;
        head     = exp_pc;
        d0       = delivered;
        repeat (6) cyc();
        chk("toggle_count", 64'(delivered - d0), 64'h2);
        chk("toggle_last_pc", {32'h0, exp_pc}, {32'h0, head + 32'd8});
        chk("toggle_idle", {63'h0, inst_valid}, 64'h0);

        // Restart, fill, then async reset mid-stream.
        fetch_en = 1'b1;
        repeat (5) cyc();
        inst_ready = 1'b0;
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'h0, inst_valid}, 64'h0);
        chk("mid_rst_pc", {32'h0, inst_pc}, 64'h0);
        chk("mid_rst_inflight", {63'h0, dut.inflight_r}, 64'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        exp_pc     = 32'h0;
        cyc();
        chk("post_rst_valid0", {63'h0, inst_valid}, 64'h0);
        cyc();
        chk("post_rst_valid1", {63'h0, inst_valid}, 64'h1);
        chk("post_rst_pc", {32'h0, inst_pc}, 64'h0);
        repeat (4) cyc();

        // Randomized traffic against the in-order stream reference.
        d0 = delivered;
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            cyc();
        end
        redirect_valid = 1'b0;
        chk("random_progress", {63'h0, (delivered - d0) > 50}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_fetch.md
# rom_fetch

Instruction fetch front-end that sits between the core's decode stage and the 1 KiB boot ROM. It drives the ROM word address and captures the ROM's registered read data one cycle later. Fetched words go into a small prefetch FIFO, and the FIFO presents `{pc, instruction}` to decode over a valid/ready handshake. Control-flow redirects flush all buffered and in-flight fetches and restart at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: first PC fetched after reset.
- `ADDR_W`, default 10: ROM byte-address width.
- `DEPTH`, default 2: prefetch FIFO entries. Power of two, ≥2.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `fetch_en`, in, 1: allows new fetches to issue. In-flight fetches complete regardless.
- `rom_addr`, out, ADDR_W: byte address to the ROM. Bits [1:0] are always 0.
- `rom_data`, in, 32: ROM read data, valid the cycle after `rom_addr` is presented.
- `redirect_valid`, in, 1: one-cycle request to restart fetch.
- `redirect_pc`, in, 32: redirect target. Bits [1:0] are ignored and forced to 0.
- `inst_valid`, out, 1: FIFO head is valid.
- `inst_ready`, in, 1: decode accepts the head.
- `inst_data`, out, 32: instruction word at the FIFO head.
- `inst_pc`, out, 32: full 32-bit PC of `inst_data`.

## Operation
- State:
  - `fetch_pc` (32 b)
  - `inflight_q` (1 b) and `inflight_pc_q` (32 b)
  - FIFO of DEPTH × 64 b, with read/write pointers and `count`.
- ROM address:
  - `rom_addr = redirect_valid ? redirect_pc[ADDR_W-1:2],2'b00 : fetch_pc[ADDR_W-1:2],2'b00`.
  - The ROM reads every cycle. Results are kept only when a fetch was issued.
- Issue:
  - `pop = inst_valid & inst_ready`.
  - A fetch issues when `fetch_en` is 1 and `count + inflight_q - pop < DEPTH`.
  - On issue: `inflight_q <= 1`, `inflight_pc_q <= fetch_pc`, `fetch_pc <= fetch_pc + 4`.
  - Otherwise `inflight_q <= 0`.
- Capture: when `inflight_q` is 1, push `{inflight_pc_q, rom_data}` at the FIFO tail.
- PC wrap-around: only `fetch_pc[ADDR_W-1:0]` addresses the ROM. PC 0x3FC is followed by 0x400, which reads ROM word 0, and `inst_pc` reports 0x400. The 32-bit `fetch_pc` wraps modulo 2^32.
- Redirect (highest priority):
  - FIFO is emptied (`count <= 0`, pointers reset) and `inflight_q`'s data is discarded (no push).
  - The redirect target issues immediately if `fetch_en` is 1: `inflight_q <= 1`, `inflight_pc_q <= redirect_pc & ~3`, `fetch_pc <= (redirect_pc & ~3) + 4`.
  - If `fetch_en` is 0: `fetch_pc <= redirect_pc & ~3` and `inflight_q <= 0`.
  - A pop that completes in the redirect cycle still counts as consumed by decode.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- The FIFO is never overrun, because the issue rule reserves a slot for every in-flight fetch. No push can occur while `count == DEPTH`.
- `fetch_en` deassert: no new issues. The in-flight word is still captured and the FIFO drains normally.

## Timing
- Reset values (async assert):
  - `fetch_pc = RESET_PC`, `inflight_q = 0`, `inflight_pc_q = 0`, `count = 0`.
  - `inst_valid = 0`, `inst_data = 0`, `inst_pc = 0`.
  - `rom_addr = RESET_PC[ADDR_W-1:0]` with low 2 bits cleared.
- Reset deassert is synchronous to `clk` at the system level. With `fetch_en = 1`, the first edge issues RESET_PC and `inst_valid` rises 2 edges after the first active edge.
- Fetch latency: issue in cycle N, ROM data in N+1 (pushed at the N+1 edge), `inst_valid` in N+2.
- Redirect latency: `redirect_valid` in cycle R gives `inst_valid` with `inst_pc = redirect_pc` in R+2. `inst_valid` is 0 in R+1.
- Throughput: with DEPTH ≥ 2 and `inst_ready` held at 1, one instruction per cycle in steady state.
- `inst_valid`, `inst_data` and `inst_pc` come only from registers (FIFO head). The issue decision may depend combinationally on `inst_ready`.
- Reset mid-operation clears all state immediately, including the FIFO and in-flight data. No stale instruction is presented after reset release.

## Test plan
- Reset, then `fetch_en = 1`, `inst_ready = 1`. Required: `inst_pc` = 0x0, 0x4, 0x8, … on consecutive cycles from cycle 2, with `inst_data` = 0x00000093, 0x00000113, 0x00000193.
- Backpressure: `inst_ready = 0` for 10 cycles. Required: `count` saturates at DEPTH and `fetch_pc` stops advancing. Releasing `inst_ready` delivers every PC in order with none skipped or duplicated.
- Redirect to 0x16C while the FIFO is full. Required: `inst_valid = 0` in R+1. In R+2, `inst_pc = 0x16C` and `inst_data = 0xfe010113`. No pre-redirect PC appears afterwards.
- Misaligned redirect to 0x16E. Required: identical to the 0x16C case.
- Wrap: redirect to 0x3FC. Required: next instructions are `inst_pc` 0x3FC then 0x400, with `inst_data` for 0x400 = 0x00000093.
- `fetch_en` toggled 1→0 with one fetch in flight, then async `rst_n` pulsed mid-stream. Required: the in-flight word is delivered and no further issues occur. After reset, `inst_valid` = 0 until a clean restart at RESET_PC.
